vx_lmem_responder: RTL and testbench

Local-memory responder for the core data-request interface: the memory-side end of the per-thread request/response protocol that the LSU drives. It accepts up to NUM_THREADS lane requests per cycle, resolves bank conflicts by serializing lanes through per-lane ready, performs banked SRAM reads and writes, and returns one registered multi-lane read response per cycle. Writes complete silently with no response. It sits beside the data cache as the responder for local-memory address ranges.

---
 rtl/vx_lmem_responder.sv | 178 +++++++++++++++++
 tb/tb_vx_lmem_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/vx_lmem_responder.sv
// Banked local-memory responder: per-bank arbitration with read merging,
// byte-enabled writes and one registered multi-lane read response per cycle.
module vx_lmem_responder #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_BANKS   = 4,
    parameter int SIZE_WORDS  = 1024,
    parameter int TAG_WIDTH   = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_THREADS-1:0]                req_valid,
    input  logic [NUM_THREADS-1:0]                req_rw,
    input  logic [NUM_THREADS-1:0][29:0]          req_addr,
    input  logic [NUM_THREADS-1:0][3:0]           req_byteen,
    input  logic [NUM_THREADS-1:0][31:0]          req_data,
    input  logic [NUM_THREADS-1:0][TAG_WIDTH-1:0] req_tag,
    output logic [NUM_THREADS-1:0]                req_ready,
    output logic [NUM_THREADS-1:0]                rsp_valid,
    output logic [NUM_THREADS-1:0][31:0]          rsp_data,
    output logic [TAG_WIDTH-1:0]                  rsp_tag,
    input  logic                                  rsp_ready,
    output logic [31:0]                           perf_conflicts
);

    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int LANE_W    = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
    localparam int ADDR_BITS = $clog2(SIZE_WORDS);
    localparam int ROW_BITS  = ADDR_BITS - BANK_BITS;
    localparam int ROWS      = SIZE_WORDS / NUM_BANKS;

    logic                                  stall_s;
    logic                                  conflict_s;
    logic [NUM_THREADS-1:0][BANK_W-1:0]    lane_bank_s;
    logic [NUM_THREADS-1:0][ROW_BITS-1:0]  lane_row_s;
    logic [NUM_BANKS-1:0]                  bank_hit_s;
    logic [NUM_BANKS-1:0][LANE_W-1:0]      bank_sel_s;
    logic [NUM_THREADS-1:0]                served_s;
    logic [NUM_THREADS-1:0]                fire_rd_s;
    logic [TAG_WIDTH-1:0]                  tag_s;
    logic [NUM_BANKS-1:0]                  bank_we_s;
    logic [NUM_BANKS-1:0]                  bank_re_s;
    logic [NUM_BANKS-1:0][ROW_BITS-1:0]    bank_row_s;
    logic [NUM_BANKS-1:0][31:0]            bank_wdata_s;
    logic [NUM_BANKS-1:0][3:0]             bank_byteen_s;
    logic [31:0]                           bank_rdata_s [NUM_BANKS];

    logic [NUM_THREADS-1:0]                rsp_valid_r;
    logic [TAG_WIDTH-1:0]                  rsp_tag_r;
    logic [NUM_THREADS-1:0][BANK_W-1:0]    lane_bank_r;
    logic [31:0]                           perf_conflicts_r;

    assign stall_s = (|rsp_valid_r) && !rsp_ready;

    // Split each lane address into bank select and row; upper bits alias.
    always_comb begin
        for (int i = 0; i < NUM_THREADS; i++) begin
            lane_bank_s[i] = (NUM_BANKS > 1) ? req_addr[i][BANK_W-1:0] : '0;
            lane_row_s[i]  = req_addr[i][ADDR_BITS-1:BANK_BITS];
        end
    end

    // Per bank, the lowest-index valid lane wins (descending scan, last match sticks).
    always_comb begin
        bank_hit_s = '0;
        bank_sel_s = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int i = NUM_THREADS - 1; i >= 0; i--) begin
                bank_sel_s[b] = (req_valid[i] && (lane_bank_s[i] == BANK_W'(b))) ? LANE_W'(i) : bank_sel_s[b];
                bank_hit_s[b] = bank_hit_s[b] | (req_valid[i] && (lane_bank_s[i] == BANK_W'(b)));
            end
        end
    end

    // A lane is served if it is its bank's winner or a read of the winner's read address.
    always_comb begin
        served_s = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            served_s[i] = req_valid[i] &&
                ((bank_sel_s[lane_bank_s[i]] == LANE_W'(i)) ||
                 (!req_rw[i] && !req_rw[bank_sel_s[lane_bank_s[i]]] &&
                  (req_addr[i] == req_addr[bank_sel_s[lane_bank_s[i]]])));
        end
    end

    assign req_ready  = served_s & {NUM_THREADS{!stall_s}};
    assign fire_rd_s  = req_ready & ~req_rw;
    assign conflict_s = !stall_s && (|(req_valid & ~served_s));

    // Response tag comes from the lowest fired read lane.
    always_comb begin
        tag_s = '0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            tag_s = fire_rd_s[i] ? req_tag[i] : tag_s;
        end
    end

    // Bank port controls are driven by the winning lane of each bank.
    always_comb begin
        bank_we_s     = '0;
        bank_re_s     = '0;
        bank_row_s    = '0;
        bank_wdata_s  = '0;
        bank_byteen_s = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_we_s[b]     = !stall_s && bank_hit_s[b] && req_rw[bank_sel_s[b]];
            bank_re_s[b]     = !stall_s && bank_hit_s[b] && !req_rw[bank_sel_s[b]];
            bank_row_s[b]    = lane_row_s[bank_sel_s[b]];
            bank_wdata_s[b]  = req_data[bank_sel_s[b]];
            bank_byteen_s[b] = req_byteen[bank_sel_s[b]];
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [31:0] mem [ROWS];
        logic [31:0] rdata_r;

        // Byte-enabled write port; suppressed in a reset cycle.
        always_ff @(posedge clk) begin
            if (!reset && bank_we_s[b]) begin
                for (int k = 0; k < 4; k++) begin
                    if (bank_byteen_s[b][k]) begin
                        mem[bank_row_s[b]][8*k +: 8] <= bank_wdata_s[b][8*k +: 8];
                    end
                end
            end
        end

        // Synchronous read port; only loads on a fired read so it holds through stalls.
        always_ff @(posedge clk) begin
            if (reset) begin
                rdata_r <= 32'h0000_0000;
            end else if (bank_re_s[b]) begin
                rdata_r <= mem[bank_row_s[b]];
            end
        end

        assign bank_rdata_s[b] = rdata_r;
    end

    // Output register: valid/tag/lane-to-bank steering, plus the conflict counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_r      <= '0;
            rsp_tag_r        <= '0;
            lane_bank_r      <= '0;
            perf_conflicts_r <= 32'd0;
        end else begin
            if (!stall_s) begin
                rsp_valid_r <= fire_rd_s;
                if (|fire_rd_s) begin
                    rsp_tag_r <= tag_s;
                end
                for (int i = 0; i < NUM_THREADS; i++) begin
                    if (fire_rd_s[i]) begin
                        lane_bank_r[i] <= lane_bank_s[i];
                    end
                end
            end
            if (conflict_s) begin
                perf_conflicts_r <= perf_conflicts_r + 32'd1;
            end
        end
    end

    // Route each lane's bank read register to its response slot.
    always_comb begin
        rsp_data = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            rsp_data[i] = bank_rdata_s[lane_bank_r[i]];
        end
    end

    assign rsp_valid      = rsp_valid_r;
    assign rsp_tag        = rsp_tag_r;
    assign perf_conflicts = perf_conflicts_r;

endmodule

// File: tb/tb_vx_lmem_responder.sv
// Directed self-checking bench for vx_lmem_responder (4 lanes, 4 banks).
module tb_vx_lmem_responder;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       req_valid;
    logic [3:0]       req_rw;
    logic [3:0][29:0] req_addr;
    logic [3:0][3:0]  req_byteen;
    logic [3:0][31:0] req_data;
    logic [3:0][7:0]  req_tag;
    logic [3:0]       req_ready;
    logic [3:0]       rsp_valid;
    logic [3:0][31:0] rsp_data;
    logic [7:0]       rsp_tag;
    logic             rsp_ready;
    logic [31:0]      perf_conflicts;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vx_lmem_responder dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
        .req_byteen(req_byteen), .req_data(req_data), .req_tag(req_tag),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .rsp_ready(rsp_ready), .perf_conflicts(perf_conflicts)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = '0; req_rw = '0; req_addr = '0;
        req_byteen = '0; req_data = '0; req_tag = '0;
    endtask

    task automatic lane(input int i, input logic rw, input logic [29:0] a,
                        input logic [3:0] be, input logic [31:0] d, input logic [7:0] t);
        req_valid[i] = 1'b1; req_rw[i] = rw; req_addr[i] = a;
        req_byteen[i] = be; req_data[i] = d; req_tag[i] = t;
    endtask

    task automatic test_reset();
        reset = 1'b1; rsp_ready = 1'b1; idle();
        step(); step();
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rst_valid: got %b want 0000", rsp_valid); end
        checks++; if (rsp_tag !== 8'h00) begin errors++; $display("FAIL rst_tag: got %h want 00", rsp_tag); end
        checks++; if (rsp_data !== 128'h0) begin errors++; $display("FAIL rst_data: got %h want 0", rsp_data); end
        checks++; if (perf_conflicts !== 32'd0) begin errors++; $display("FAIL rst_perf: got %0d want 0", perf_conflicts); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        idle();
        for (int i = 0; i < 4; i++) lane(i, 1'b1, 30'(16 + i), 4'hF, 32'(160 + i), 8'h01);
        #1;
        checks++; if (req_ready !== 4'b1111) begin errors++; $display("FAIL wr_ready: got %b want 1111", req_ready); end
        step();
        idle();
        for (int i = 0; i < 4; i++) lane(i, 1'b0, 30'(16 + i), 4'h0, 32'h0, 8'h5A);
        #1;
        checks++; if (req_ready !== 4'b1111) begin errors++; $display("FAIL rd_ready: got %b want 1111", req_ready); end
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL wr_norsp: got %b want 0000", rsp_valid); end
        step();
        idle();
        checks++; if (rsp_valid !== 4'b1111) begin errors++; $display("FAIL wrrd_valid: got %b want 1111", rsp_valid); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rsp_data[i] !== 32'(160 + i)) begin errors++; $display("FAIL wrrd_data%0d: got %h want %h", i, rsp_data[i], 32'(160 + i)); end
        end
        checks++; if (rsp_tag !== 8'h5A) begin errors++; $display("FAIL wrrd_tag: got %h want 5a", rsp_tag); end
    endtask

    task automatic test_conflict();
        for (int k = 0; k < 4; k++) begin
            idle();
            lane(0, 1'b1, 30'(4 * k), 4'hF, 32'(192 + k), 8'h00);
            step();
        end
        idle();
        for (int i = 0; i < 4; i++) lane(i, 1'b0, 30'(4 * i), 4'h0, 32'h0, 8'h33);
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (req_ready !== 4'(1 << k)) begin errors++; $display("FAIL cf_ready%0d: got %b want %b", k, req_ready, 4'(1 << k)); end
            step();
            checks++; if (rsp_valid !== 4'(1 << k)) begin errors++; $display("FAIL cf_valid%0d: got %b want %b", k, rsp_valid, 4'(1 << k)); end
            checks++; if (rsp_data[k] !== 32'(192 + k)) begin errors++; $display("FAIL cf_data%0d: got %h want %h", k, rsp_data[k], 32'(192 + k)); end
            checks++; if (rsp_tag !== 8'h33) begin errors++; $display("FAIL cf_tag%0d: got %h want 33", k, rsp_tag); end
            req_valid[k] = 1'b0;
        end
        idle();
        checks++; if (perf_conflicts !== 32'd3) begin errors++; $display("FAIL cf_perf: got %0d want 3", perf_conflicts); end
    endtask

    task automatic test_merge();
        idle();
        lane(0, 1'b1, 30'h20, 4'hF, 32'hDEADBEEF, 8'h00);
        step();
        idle();
        for (int i = 0; i < 4; i++) lane(i, 1'b0, 30'h20, 4'h0, 32'h0, 8'h77);
        #1;
        checks++; if (req_ready !== 4'b1111) begin errors++; $display("FAIL mg_ready: got %b want 1111", req_ready); end
        step();
        idle();
        checks++; if (rsp_valid !== 4'b1111) begin errors++; $display("FAIL mg_valid: got %b want 1111", rsp_valid); end
        checks++; if (rsp_data !== {4{32'hDEADBEEF}}) begin errors++; $display("FAIL mg_data: got %h want 4x deadbeef", rsp_data); end
        checks++; if (rsp_tag !== 8'h77) begin errors++; $display("FAIL mg_tag: got %h want 77", rsp_tag); end
        checks++; if (perf_conflicts !== 32'd3) begin errors++; $display("FAIL mg_perf: got %0d want 3", perf_conflicts); end
    endtask

    task automatic test_byte_write();
        idle(); lane(0, 1'b1, 30'd5, 4'hF, 32'h11223344, 8'h00); step();
        idle(); lane(0, 1'b1, 30'd5, 4'b0010, 32'hFFFFFFFF, 8'h00); step();
        idle(); lane(0, 1'b1, 30'd5, 4'b0000, 32'h00000000, 8'h00); step();
        idle(); lane(0, 1'b0, 30'd5, 4'h0, 32'h0, 8'h09); step();
        idle();
        checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL bw_valid: got %b want 0001", rsp_valid); end
        checks++; if (rsp_data[0] !== 32'h1122FF44) begin errors++; $display("FAIL bw_data: got %h want 1122ff44", rsp_data[0]); end
        checks++; if (rsp_tag !== 8'h09) begin errors++; $display("FAIL bw_tag: got %h want 09", rsp_tag); end
    endtask

    task automatic test_backpressure();
        idle();
        lane(0, 1'b0, 30'd5, 4'h0, 32'h0, 8'h44);
        lane(1, 1'b0, 30'h12, 4'h0, 32'h0, 8'h44);
        step();
        idle();
        checks++; if (rsp_valid !== 4'b0011) begin errors++; $display("FAIL bp_first: got %b want 0011", rsp_valid); end
        rsp_ready = 1'b0;
        lane(0, 1'b0, 30'h13, 4'h0, 32'h0, 8'h45);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready%0d: got %b want 0000", c, req_ready); end
            checks++; if (rsp_valid !== 4'b0011 || rsp_tag !== 8'h44 || rsp_data[0] !== 32'h1122FF44 || rsp_data[1] !== 32'hA2) begin
                errors++; $display("FAIL bp_hold%0d: got v=%b t=%h d0=%h d1=%h want v=0011 t=44 d0=1122ff44 d1=a2", c, rsp_valid, rsp_tag, rsp_data[0], rsp_data[1]);
            end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_release: got %b want 0001", req_ready); end
        step();
        idle();
        checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL bp_valid: got %b want 0001", rsp_valid); end
        checks++; if (rsp_data[0] !== 32'hA3) begin errors++; $display("FAIL bp_data: got %h want a3", rsp_data[0]); end
        checks++; if (rsp_tag !== 8'h45) begin errors++; $display("FAIL bp_tag: got %h want 45", rsp_tag); end
        checks++; if (perf_conflicts !== 32'd3) begin errors++; $display("FAIL bp_perf: got %0d want 3", perf_conflicts); end
    endtask

    task automatic test_mixed();
        idle();
        lane(0, 1'b1, 30'h30, 4'hF, 32'h55, 8'h66);
        lane(1, 1'b0, 30'h34, 4'h0, 32'h0, 8'h66);
        lane(2, 1'b0, 30'h11, 4'h0, 32'h0, 8'h66);
        #1;
        checks++; if (req_ready !== 4'b0101) begin errors++; $display("FAIL mx_ready: got %b want 0101", req_ready); end
        step();
        checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL mx_valid: got %b want 0100", rsp_valid); end
        checks++; if (rsp_data[2] !== 32'hA1) begin errors++; $display("FAIL mx_data: got %h want a1", rsp_data[2]); end
        checks++; if (perf_conflicts !== 32'd4) begin errors++; $display("FAIL mx_perf: got %0d want 4", perf_conflicts); end
        req_valid[0] = 1'b0; req_valid[2] = 1'b0; req_addr[1] = 30'h30;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mx_ready2: got %b want 0010", req_ready); end
        step();
        idle();
        checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL mx_valid2: got %b want 0010", rsp_valid); end
        checks++; if (rsp_data[1] !== 32'h55) begin errors++; $display("FAIL mx_vis: got %h want 55", rsp_data[1]); end
        checks++; if (perf_conflicts !== 32'd4) begin errors++; $display("FAIL mx_perf2: got %0d want 4", perf_conflicts); end
    endtask

    task automatic test_reset_mid();
        idle();
        lane(0, 1'b0, 30'h10, 4'h0, 32'h0, 8'h12);
        step();
        idle();
        checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL rm_pending: got %b want 0001", rsp_valid); end
        reset = 1'b1;
        lane(1, 1'b0, 30'h11, 4'h0, 32'h0, 8'h13);
        lane(3, 1'b1, 30'h13, 4'hF, 32'hBAD, 8'h13);
        step();
        reset = 1'b0;
        idle();
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rm_valid: got %b want 0000", rsp_valid); end
        checks++; if (perf_conflicts !== 32'd0) begin errors++; $display("FAIL rm_perf: got %0d want 0", perf_conflicts); end
        checks++; if (rsp_tag !== 8'h00) begin errors++; $display("FAIL rm_tag: got %h want 00", rsp_tag); end
        for (int i = 0; i < 4; i++) lane(i, 1'b0, 30'(16 + i), 4'h0, 32'h0, 8'h21);
        #1;
        checks++; if (req_ready !== 4'b1111) begin errors++; $display("FAIL rm_ready: got %b want 1111", req_ready); end
        step();
        idle();
        for (int i = 0; i < 4; i++) begin
            checks++; if (rsp_data[i] !== 32'(160 + i)) begin errors++; $display("FAIL rm_data%0d: got %h want %h", i, rsp_data[i], 32'(160 + i)); end
        end
        checks++; if (rsp_tag !== 8'h21) begin errors++; $display("FAIL rm_tag2: got %h want 21", rsp_tag); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_conflict();
        test_merge();
        test_byte_write();
        test_backpressure();
        test_mixed();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule
